timing_decode_unit: RTL
=======================

TIMING_DECODE_UNIT -- requirements
Module: timing_decode_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 The block SHALL have these further ports:
- START  in  1  leave IDLE, begin fetching
- HOLD  in  1  memory wait; freezes the sequence counter
- SC_CLR  in  1  end-of-instruction, from the control unit
- IR  in  19  current instruction register value
- T0..T6  out  1 each  one-hot timing phases
- D1  out  8  opcode decode, one-hot of IR[18:16]
- D2  out  16  register-op decode, one-hot of IR[15:12]; all zero unless D1[7]
- Dv, Dw  out  4 each  one-hot of IR[15:14] and IR[13:12]; all zero when D1[7]
- Dx, Dy, Dz  out  4 each  one-hot of IR[11:10], IR[9:8] and IR[7:6]; all zero unless D1[7]
- RUNNING  out  1  FSM is in RUN
- HALTED  out  1  FSM is in HALT
- SEQ_ERR  out  1  one-cycle pulse on sequence overrun
- INSTR_CNT  out  16  number of completed instructions

Function
REQ-003 The FSM SHALL have three states: IDLE, RUN and HALT.
REQ-004 The sequence counter SC SHALL be 3 bits and meaningful only in RUN; Tn = RUN && (SC == n), for n = 0..6.
REQ-005 In IDLE and HALT, all Tn SHALL be 0.
REQ-006 In IDLE, START=1 SHALL move the FSM to RUN with SC=0, so T0 is asserted in the next cycle.
REQ-007 In RUN, the SC update at each edge SHALL follow this priority: SC_CLR -> SC=0; else HOLD -> SC held; else SC+1.
REQ-008 In RUN, if SC==6 with SC_CLR=0 and HOLD=0, SC SHALL go to 0 and SEQ_ERR SHALL pulse high for one cycle.
REQ-009 In RUN, if SC==6 with HOLD=1 and SC_CLR=0, SC SHALL be held and no error SHALL be raised.
REQ-010 HALT instruction: in RUN, if T2=1, D1[0]=1 and IR[15:0]==16'hFFFF, the FSM SHALL enter HALT at that edge.
- In that case the halt SHALL take priority over SC_CLR and HOLD.
- INSTR_CNT SHALL increment by 1 for the halting instruction.
REQ-011 In HALT, START SHALL be ignored; only rst_n SHALL exit HALT.
REQ-012 In IDLE and HALT, START, HOLD and SC_CLR SHALL have no effect on SC, apart from the IDLE START transition in REQ-006.
REQ-013 INSTR_CNT SHALL increment by 1 on each edge where RUN && SC_CLR, and SHALL wrap from 16'hFFFF to 0.
REQ-014 The decode outputs (D1, D2, Dv, Dw, Dx, Dy, Dz) SHALL be purely combinational from IR, with zero latency and independent of FSM state.
REQ-015 Exactly one bit of D1 SHALL be set at all times.
REQ-016 RUNNING, HALTED, SEQ_ERR, INSTR_CNT and the Tn outputs SHALL be registered or decoded from registered state only, with no combinational path from the inputs.

Reset
REQ-017 On rst_n=0, the block SHALL asynchronously set: FSM=IDLE, SC=0, all Tn=0, RUNNING=0, HALTED=0, SEQ_ERR=0, INSTR_CNT=0.
REQ-018 A reset asserted mid-instruction SHALL abandon the instruction with no count increment.
REQ-019 After reset release, the FSM SHALL stay in IDLE until START=1 is sampled.

Structure
REQ-020 A shared package SHALL hold:
- the FSM state encoding (IDLE=2'b00, RUN=2'b01, HALT=2'b10)
- field position constants for IR (OPC 18:16, SUB 15:12, X 11:10, Y 9:8, Z 7:6)
- the HALT pattern constant 16'hFFFF
REQ-021 The block SHALL contain exactly one sub-module, onehot_dec (a parameterised N-to-2^N decoder with an enable input), instantiated for D1, D2, Dv, Dw, Dx, Dy and Dz.

Verification
REQ-022 Reset, then START pulse, then SC_CLR asserted during T3 -> T0,T1,T2,T3 each high for one cycle in turn, then T0 again; INSTR_CNT=1.
REQ-023 HOLD=1 for 3 cycles during T2 -> T2 stays high for 4 cycles, then T3 follows; no SEQ_ERR.
REQ-024 No SC_CLR through T6 -> T0 follows T6; SEQ_ERR high for exactly that one cycle; INSTR_CNT unchanged.
REQ-025 IR=19'b000_1111111111111111 reaching T2 -> HALTED=1 next cycle with all Tn=0; a later START pulse leaves HALTED=1.
REQ-026 IR=19'h7A400 (opcode 7, sub 10, x=1) -> D1=8'h80, D2=16'h0400, Dx=4'b0010, Dv=0; IR=19'h1C000 -> D1=8'h02, Dv=4'b1000, Dw=4'b0001, D2=0.
REQ-027 rst_n asserted at T4, mid-instruction -> all outputs cleared immediately; INSTR_CNT=0; FSM in IDLE until START.

Source files
------------

// File: rtl/timing_decode_unit_pkg.sv
// Shared definitions for the timing/decode unit: FSM encoding, instruction
// register field positions and the halt instruction pattern.
package timing_decode_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    localparam int IR_W   = 19;

    localparam int OPC_HI = 18;
    localparam int OPC_LO = 16;
    localparam int SUB_HI = 15;
    localparam int SUB_LO = 12;
    localparam int X_HI   = 11;
    localparam int X_LO   = 10;
    localparam int Y_HI   = 9;
    localparam int Y_LO   = 8;
    localparam int Z_HI   = 7;
    localparam int Z_LO   = 6;

    localparam logic [15:0] HALT_PATTERN = 16'hFFFF;

    localparam logic [2:0] SC_LAST = 3'd6;

endpackage

// File: rtl/timing_decode_unit_if.sv
// Control/decode bundle between the control unit (master) and the timing unit (slave).
interface timing_decode_unit_if;
    import timing_decode_unit_pkg::*;

    logic              START;
    logic              HOLD;
    logic              SC_CLR;
    logic [IR_W-1:0]   IR;

    logic              T0;
    logic              T1;
    logic              T2;
    logic              T3;
    logic              T4;
    logic              T5;
    logic              T6;
    logic [7:0]        D1;
    logic [15:0]       D2;
    logic [3:0]        Dv;
    logic [3:0]        Dw;
    logic [3:0]        Dx;
    logic [3:0]        Dy;
    logic [3:0]        Dz;
    logic              RUNNING;
    logic              HALTED;
    logic              SEQ_ERR;
    logic [15:0]       INSTR_CNT;

    modport master (
        output START, HOLD, SC_CLR, IR,
        input  T0, T1, T2, T3, T4, T5, T6,
        input  D1, D2, Dv, Dw, Dx, Dy, Dz,
        input  RUNNING, HALTED, SEQ_ERR, INSTR_CNT
    );

    modport slave (
        input  START, HOLD, SC_CLR, IR,
        output T0, T1, T2, T3, T4, T5, T6,
        output D1, D2, Dv, Dw, Dx, Dy, Dz,
        output RUNNING, HALTED, SEQ_ERR, INSTR_CNT
    );

endinterface

// File: rtl/timing_decode_unit_onehot_dec.sv
// Generic N-to-2^N one-hot decoder; output is all zero when disabled.
module onehot_dec #(
    parameter int N = 3
) (
    input  logic                en,
    input  logic [N-1:0]        sel,
    output logic [(1<<N)-1:0]   dout
);

    // Set the selected bit only while enabled.
    always_comb begin
        dout = '0;
        if (en) begin
            dout[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/timing_decode_unit.sv
// Instruction timing sequencer (T0..T6) with combinational opcode/operand decode.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for START; all T phases low
//   RUN     | sequencing T0..T6 from SC; counts completed instructions
//   HALT    | halt instruction executed; only reset leaves this state
module timing_decode_unit
    import timing_decode_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    timing_decode_unit_if.slave  bus
);

    state_t       state;
    logic [2:0]   sc;
    logic         seq_err;
    logic [15:0]  instr_cnt;

    logic [7:0]   d1;
    logic [15:0]  d2;
    logic [3:0]   dv;
    logic [3:0]   dw;
    logic [3:0]   dx;
    logic [3:0]   dy;
    logic [3:0]   dz;
    logic         reg_op;
    logic         halt_hit;
    logic [6:0]   t_vec;

    // Opcode 7 selects the register-operation format; other opcodes use Dv/Dw.
    assign reg_op = d1[7];

    onehot_dec #(.N(3)) u_dec_d1 (.en(1'b1),    .sel(bus.IR[OPC_HI:OPC_LO]), .dout(d1));
    onehot_dec #(.N(4)) u_dec_d2 (.en(reg_op),  .sel(bus.IR[SUB_HI:SUB_LO]), .dout(d2));
    onehot_dec #(.N(2)) u_dec_dv (.en(!reg_op), .sel(bus.IR[SUB_HI:SUB_HI-1]), .dout(dv));
    onehot_dec #(.N(2)) u_dec_dw (.en(!reg_op), .sel(bus.IR[SUB_LO+1:SUB_LO]), .dout(dw));
    onehot_dec #(.N(2)) u_dec_dx (.en(reg_op),  .sel(bus.IR[X_HI:X_LO]), .dout(dx));
    onehot_dec #(.N(2)) u_dec_dy (.en(reg_op),  .sel(bus.IR[Y_HI:Y_LO]), .dout(dy));
    onehot_dec #(.N(2)) u_dec_dz (.en(reg_op),  .sel(bus.IR[Z_HI:Z_LO]), .dout(dz));

    // The halt instruction is recognised only at T2, and wins over SC_CLR/HOLD.
    assign halt_hit = (state == ST_RUN) && (sc == 3'd2) && d1[0]
                      && (bus.IR[SUB_HI:0] == HALT_PATTERN);

    // Sequencer FSM: state, sequence counter, overrun pulse and instruction count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sc        <= '0;
            seq_err   <= 1'b0;
            instr_cnt <= '0;
        end else begin
            seq_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.START) begin
                        state <= ST_RUN;
                        sc    <= '0;
                    end
                end
                ST_RUN: begin
                    if (halt_hit) begin
                        state     <= ST_HALT;
                        sc        <= '0;
                        instr_cnt <= instr_cnt + 16'd1;
                    end else if (bus.SC_CLR) begin
                        sc        <= '0;
                        instr_cnt <= instr_cnt + 16'd1;
                    end else if (bus.HOLD) begin
                        sc <= sc;
                    end else if (sc == SC_LAST) begin
                        // Ran past T6 without an end-of-instruction: restart and flag it.
                        sc      <= '0;
                        seq_err <= 1'b1;
                    end else begin
                        sc <= sc + 3'd1;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_IDLE;
                    sc    <= '0;
                end
            endcase
        end
    end

    // Timing phases decoded from registered state only.
    always_comb begin
        t_vec = '0;
        for (int n = 0; n < 7; n++) begin
            t_vec[n] = (state == ST_RUN) && (sc == 3'(n));
        end
    end

    assign bus.T0        = t_vec[0];
    assign bus.T1        = t_vec[1];
    assign bus.T2        = t_vec[2];
    assign bus.T3        = t_vec[3];
    assign bus.T4        = t_vec[4];
    assign bus.T5        = t_vec[5];
    assign bus.T6        = t_vec[6];
    assign bus.D1        = d1;
    assign bus.D2        = d2;
    assign bus.Dv        = dv;
    assign bus.Dw        = dw;
    assign bus.Dx        = dx;
    assign bus.Dy        = dy;
    assign bus.Dz        = dz;
    assign bus.RUNNING   = (state == ST_RUN);
    assign bus.HALTED    = (state == ST_HALT);
    assign bus.SEQ_ERR   = seq_err;
    assign bus.INSTR_CNT = instr_cnt;

endmodule
